// File: rtl/elliptic_curve_structs.sv
// Shared curve parameters and field-arithmetic types.
// The inverter state enum lives here so point FSMs can observe it.
package elliptic_curve_structs;

    localparam int CURVE_WIDTH = 256;

    typedef struct packed {
        logic [CURVE_WIDTH-1:0] p;
        logic [CURVE_WIDTH-1:0] a;
        logic [CURVE_WIDTH-1:0] b;
    } curve_params_t;

    // secp256k1 field prime and curve coefficients
    localparam curve_params_t params = '{
        p: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
        a: 256'd0,
        b: 256'd7
    };

    typedef enum logic [2:0] {
        INV_INIT,
        INV_REDUCE,
        INV_CHECK,
        INV_HALVE_U,
        INV_HALVE_V,
        INV_SUB,
        INV_FINISH,
        INV_FAIL
    } inv_state_t;

endpackage

// File: rtl/mod_half.sv
// Halving modulo p: x even ? x/2 : (x+p)/2, for x < p.
module mod_half
    import elliptic_curve_structs::*;
#(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH:0] x,
    output logic [WIDTH:0] y
);

    localparam logic [WIDTH:0] P = {1'b0, params.p[WIDTH-1:0]};

    logic [WIDTH:0] sum;

    // x < p < 2^WIDTH, so x + p fits in WIDTH+1 bits
    assign sum = x + P;
    assign y   = x[0] ? (sum >> 1) : (x >> 1);

endmodule

// File: rtl/reg_256.sv
// Load-enabled storage register, width overridable.
module reg_256 #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (load) q <= d;
    end

endmodule

// File: rtl/modular_inverse.sv
// Binary extended Euclidean inverse: result = a^-1 mod p.
// One add, subtract or shift per clock; Done holds until Reset.
module modular_inverse
    import elliptic_curve_structs::*;
#(
    parameter int WIDTH      = 256,
    parameter int MAX_CYCLES = 4 * WIDTH + 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] a,
    output logic             Done,
    output logic             Invalid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [WIDTH:0] P = {1'b0, params.p[WIDTH-1:0]};
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYCLES);

    inv_state_t state;
    inv_state_t next;

    logic [WIDTH:0] u, v, x1, x2;
    logic [WIDTH:0] u_d, v_d, x1_d, x2_d;
    logic           u_ld, v_ld, x1_ld, x2_ld;
    logic [WIDTH:0] x1_half, x2_half;
    logic [CW-1:0]  cnt;
    logic           step;

    reg_256 #(.WIDTH(WIDTH + 1)) u_reg (
        .clk(clk), .load(u_ld), .d(u_d), .q(u)
    );
    reg_256 #(.WIDTH(WIDTH + 1)) v_reg (
        .clk(clk), .load(v_ld), .d(v_d), .q(v)
    );
    reg_256 #(.WIDTH(WIDTH + 1)) x1_reg (
        .clk(clk), .load(x1_ld), .d(x1_d), .q(x1)
    );
    reg_256 #(.WIDTH(WIDTH + 1)) x2_reg (
        .clk(clk), .load(x2_ld), .d(x2_d), .q(x2)
    );

    mod_half #(.WIDTH(WIDTH)) x1_halver (.x(x1), .y(x1_half));
    mod_half #(.WIDTH(WIDTH)) x2_halver (.x(x2), .y(x2_half));

    assign step = (state == INV_HALVE_U) || (state == INV_HALVE_V)
               || (state == INV_SUB);

    always_ff @(posedge clk) begin
        if (Reset) state <= INV_INIT;
        else       state <= next;
    end

    // Watchdog counts loop steps only, never the Reduce iterations
    always_ff @(posedge clk) begin
        if (!Reset) begin
            if (state == INV_INIT) cnt <= '0;
            else if (step)         cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            INV_INIT:   next = INV_REDUCE;
            INV_REDUCE: if (u < P) next = INV_CHECK;
            INV_CHECK: begin
                if (u == '0)                    next = INV_FAIL;
                else if (u == ONE || v == ONE)  next = INV_FINISH;
                else if (cnt == CNT_MAX)        next = INV_FAIL;
                else if (!u[0])                 next = INV_HALVE_U;
                else if (!v[0])                 next = INV_HALVE_V;
                else                            next = INV_SUB;
            end
            INV_HALVE_U, INV_HALVE_V, INV_SUB: next = INV_CHECK;
            INV_FINISH, INV_FAIL:              next = state;
            default:                           next = INV_INIT;
        endcase
    end

    always_comb begin
        u_ld    = 1'b0;
        v_ld    = 1'b0;
        x1_ld   = 1'b0;
        x2_ld   = 1'b0;
        u_d     = u;
        v_d     = v;
        x1_d    = x1;
        x2_d    = x2;
        Done    = 1'b0;
        Invalid = 1'b0;
        result  = '0;
        if (!Reset) begin
            unique case (state)
                INV_INIT: begin
                    {u_ld, v_ld, x1_ld, x2_ld} = 4'hF;
                    u_d  = {1'b0, a};
                    v_d  = P;
                    x1_d = ONE;
                    x2_d = '0;
                end
                INV_REDUCE: begin
                    u_ld = (u >= P);
                    u_d  = u - P;
                end
                INV_HALVE_U: begin
                    u_ld  = 1'b1;
                    x1_ld = 1'b1;
                    u_d   = u >> 1;
                    x1_d  = x1_half;
                end
                INV_HALVE_V: begin
                    v_ld  = 1'b1;
                    x2_ld = 1'b1;
                    v_d   = v >> 1;
                    x2_d  = x2_half;
                end
                INV_SUB: begin
                    if (u >= v) begin
                        u_ld  = 1'b1;
                        x1_ld = 1'b1;
                        u_d   = u - v;
                        x1_d  = (x1 >= x2) ? x1 - x2 : x1 + P - x2;
                    end else begin
                        v_ld  = 1'b1;
                        x2_ld = 1'b1;
                        v_d   = v - u;
                        x2_d  = (x2 >= x1) ? x2 - x1 : x2 + P - x1;
                    end
                end
                INV_FINISH: begin
                    Done   = 1'b1;
                    result = (u == ONE) ? x1[WIDTH-1:0] : x2[WIDTH-1:0];
                end
                INV_FAIL: begin
                    Done    = 1'b1;
                    Invalid = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modular_inverse.sv
// Self-checking bench for modular_inverse over the secp256k1 prime.
module tb_modular_inverse;
    import elliptic_curve_structs::*;

    localparam int W = 256;
    localparam int MAXC = 4 * W + 8;
    localparam int LIMIT = 2 * MAXC + 16;
    localparam logic [W-1:0] P = params.p;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic         inv;
        logic [W-1:0] res;
    } vec_t;

    logic         clk = 1'b0;
    logic         Reset = 1'b1;
    logic [W-1:0] a = '0;
    logic         Done, Invalid;
    logic [W-1:0] result;

    int   tests = 0;
    int   failed = 0;
    logic inv_bad = 1'b0;

    modular_inverse dut (
        .clk(clk), .Reset(Reset), .a(a),
        .Done(Done), .Invalid(Invalid), .result(result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!Reset && dut.state != INV_INIT &&
            (dut.x1 >= {1'b0, P} || dut.x2 >= {1'b0, P})) begin
            if (!inv_bad)
                $display("invariant broken: x1=%h x2=%h", dut.x1, dut.x2);
            inv_bad = 1'b1;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] av, input bit scramble,
                          output int edges);
        Reset = 1'b1;
        a = av;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        inv_bad = 1'b0;
        edges = 0;
        while (!Done && edges < LIMIT) begin
            @(posedge clk);
            #1;
            edges++;
            if (scramble && edges == 1) a = ~av;
        end
    endtask

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        logic [2*W-1:0] prod;
        prod = ({{W{1'b0}}, x} * {{W{1'b0}}, y}) % {{W{1'b0}}, P};
        return prod[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_a();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W / 32; k++) r = {r[W-33:0], 32'($urandom())};
        r = r % P;
        if (r == '0) r = 1;
        return r;
    endfunction

    initial begin
        vec_t         vecs[7];
        logic [W+1:0] t;
        logic [W-1:0] inv3, half, av;
        int           edges;
        bit           held;

        t = {2'b0, P} + 1;
        if (t % 3 != 0) t = {1'b0, P, 1'b0} + 1;
        t = t / 3;
        inv3 = t[W-1:0];
        half = (P >> 1) + 1;

        vecs[0] = '{"a=1", W'(1), 1'b0, W'(1)};
        vecs[1] = '{"a=2", W'(2), 1'b0, half};
        vecs[2] = '{"a=p-1", P - 1, 1'b0, P - 1};
        vecs[3] = '{"a=0", W'(0), 1'b1, W'(0)};
        vecs[4] = '{"a=p", P, 1'b1, W'(0)};
        vecs[5] = '{"a=p+1", P + 1, 1'b0, W'(1)};
        vecs[6] = '{"a=(p+1)/2", half, 1'b0, W'(2)};

        @(posedge clk);
        #1;
        check("reset Done", W'(Done), W'(0));
        check("reset Invalid", W'(Invalid), W'(0));
        check("reset result", result, W'(0));

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, 1'b0, edges);
            check({vecs[i].name, " Done"}, W'(Done), W'(1));
            check({vecs[i].name, " Invalid"}, W'(Invalid), W'(vecs[i].inv));
            check({vecs[i].name, " result"}, result, vecs[i].res);
            check({vecs[i].name, " invariant"}, W'(inv_bad), W'(0));
            if (i == 0) check("a=1 latency edges", W'(edges), W'(3));
        end

        for (int i = 0; i < 20; i++) begin
            av = rand_a();
            run_op(av, 1'b1, edges);
            check("rand Done", W'(Done), W'(1));
            check("rand Invalid", W'(Invalid), W'(0));
            check("rand a*result mod p", mulmod(av, result), W'(1));
            check("rand invariant", W'(inv_bad), W'(0));
            check("rand cycles in bound", W'(edges <= 2 * MAXC + 4), W'(1));
        end

        // abort a long computation with a one-cycle Reset and a=3
        Reset = 1'b1;
        a = rand_a();
        @(posedge clk);
        #1;
        Reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("mid Done low", W'(Done), W'(0));
        Reset = 1'b1;
        a = W'(3);
        #1;
        check("mid reset Done low", W'(Done), W'(0));
        run_op(W'(3), 1'b0, edges);
        check("mid a=3 Done", W'(Done), W'(1));
        check("mid a=3 Invalid", W'(Invalid), W'(0));
        check("mid a=3 result", result, inv3);

        // Finish must be absorbing whatever a does afterwards
        run_op(W'(2), 1'b0, edges);
        held = 1'b1;
        for (int i = 0; i < 50; i++) begin
            a = rand_a();
            @(posedge clk);
            #1;
            if (!Done || Invalid || result !== half) held = 1'b0;
        end
        check("hold Finish stable", W'(held), W'(1));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/modular_inverse.md
Name: modular_inverse

Overview:
- Computes result = a^-1 mod params.p using the binary extended Euclidean algorithm.
- Each step is one add, one subtract or one shift, so one state-machine step per clock.
- It is the inverse counterpart of the shift-and-add modular multiplier in the field-arithmetic layer. Point add and point double use it for affine division: the caller multiplies the numerator by the inverse of the denominator.
- Operands are sampled once after Reset. Done is held high until the next Reset, matching the multiplier's start/finish convention.

Parameters:
- WIDTH, 256, operand/result width. The modulus is params.p (WIDTH bits, odd, prime).
- MAX_CYCLES, 4*WIDTH+8, watchdog bound on loop cycles before Invalid is forced.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high; restarts the block, and a is sampled in the first cycle after release.
- a  in  WIDTH  operand; must stay stable for the first cycle after Reset falls.
- Done  out  1  high when result/Invalid are final; held until Reset.
- Invalid  out  1  high with Done when no inverse exists (a ≡ 0 mod p) or the watchdog fired.
- result  out  WIDTH  a^-1 mod p, in [1, p-1]; 0 whenever Done=0 or Invalid=1.

Behaviour:
- All registers are loaded only in the states below. While Reset is high: State <= Init; outputs read Done=0, Invalid=0, result=0.
- Internal registers:
  - u, v: WIDTH+1 bits.
  - x1, x2: WIDTH+1 bits (need room for x+p before halving).
  - cnt: cycle counter, width clog2(MAX_CYCLES)+1.
- Init: u<=a, v<=p, x1<=1, x2<=0, cnt<=0. Go to Reduce.
- Reduce: if u>=p then u<=u-p and stay; else go to Check.
  - a>=p is handled iteratively; at most 2^WIDTH/p iterations, and these are not counted against the watchdog.
- Check, evaluated in priority order:
  - u==0 -> Fail.
  - u==1 or v==1 -> Finish.
  - cnt==MAX_CYCLES -> Fail.
  - u even -> HalveU.
  - v even -> HalveV.
  - else -> Sub.
- HalveU: u<=u>>1; x1 <= x1[0] ? (x1+p)>>1 : x1>>1. Return to Check.
- HalveV: the same with v/x2. Return to Check.
- Sub:
  - if u>=v: u<=u-v; x1 <= (x1>=x2) ? x1-x2 : x1+p-x2.
  - else: v<=v-u; x2 <= (x2>=x1) ? x2-x1 : x2+p-x1.
  - Return to Check.
- cnt increments on every HalveU/HalveV/Sub cycle.
- Invariant: x1, x2 stay < p at all times. The bench asserts this every cycle.
- Finish (absorbing):
  - Done=1, Invalid=0.
  - result = (u==1) ? x1 : x2, with the low WIDTH bits driven.
  - When u==1 and v==1 hold simultaneously, the u branch wins.
- Fail (absorbing): Done=1, Invalid=1, result=0.
- Latency:
  - a=1: Init, Reduce, Check -> Finish, so Done is seen on the 4th cycle after Reset falls.
  - General worst case: at most 2*WIDTH halvings plus WIDTH+1 subtractions, plus Check cycles; this must stay within MAX_CYCLES.
- Reset mid-operation: aborts immediately on the next edge; no partial result is ever visible.
- a changing after the Init cycle has no effect.
- Outputs are driven combinationally from State and registers; no output register stage.

Decomposition:
- params.p and the curve-param struct remain in the shared package elliptic_curve_structs. The state enum type (inv_state_t) is added there so point-arithmetic FSMs can monitor it.
- Registers use the existing reg_256 module with width override (#(WIDTH+1)).
- One natural sub-module: mod_half (combinational: x even ? x>>1 : (x+p)>>1), instantiated twice, for x1 and x2.

Test Plan:
- a=1 -> Done=1 on the 4th cycle after Reset release, result=1, Invalid=0.
- a=2 -> result=(p+1)/2; a=p-1 -> result=p-1; Done within MAX_CYCLES.
- a=0 and a=p -> Done=1, Invalid=1, result=0; a=p+1 (where representable) -> result=1.
- 1000 random a in [1, p-1] -> feed (a, result) to the multiplier, which must return 1. Check the x1/x2 < p assertion and cycle count ≤ MAX_CYCLES.
- Reset pulsed for 1 cycle mid-computation with new a=3 -> result = inverse of 3, i.e. (2p+1)/3 or (p+1)/3, whichever is an integer. Done never rises before that.
- Hold in Finish for 50 cycles while toggling a -> Done, result and Invalid stay constant.
